// File: rtl/lp805x_capture.sv
// lp805x input-capture unit: synchronised pin edge detect latches a prescaled
// free-running count, with CAPCTR/CAPH/CAPL/CAPST on the SFR bus.
module lp805x_capture #(
  parameter int unsigned CNT_BITLEN      = 16,
  parameter int unsigned PRESCALE_BITLEN = 7,
  parameter logic [7:0]  CAPCTR_RSTVAL   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       wr_bit,
  input  logic [7:0] wr_addr,
  input  logic [7:0] data_in,
  input  logic       bit_in,
  input  logic       rd,
  input  logic       rd_bit,
  input  logic [7:0] rd_addr,
  output tri logic [7:0] data_out,
  output tri logic       bit_out,
  output logic       capf,
  input  logic       pin_cap
);

  localparam logic [7:0] ADDR_CAPCTR = 8'hf8;
  localparam logic [7:0] ADDR_CAPH   = 8'hf2;
  localparam logic [7:0] ADDR_CAPL   = 8'hf3;
  localparam logic [7:0] ADDR_CAPST  = 8'hf4;
  localparam logic [4:0] BLK_CAPCTR  = 5'b11111;

  logic [7:0]                 capctr_q, capctr_d;
  logic [CNT_BITLEN-1:0]      cnt_q, cnt_d;
  logic [PRESCALE_BITLEN-1:0] presc_q, presc_d;
  logic [CNT_BITLEN-1:0]      cap_q, cap_d;
  logic [7:0]                 shadow_q, shadow_d;
  logic                       ovr_q, ovr_d;
  logic                       tof_q, tof_d;
  logic                       s1_q, s2_q, s3_q;
  logic [7:0]                 rdata_q, rdata_d;
  logic                       rdata_en_q, rdata_en_d;
  logic                       rbit_q, rbit_d;
  logic                       rbit_en_q, rbit_en_d;

  logic [2:0]                 ps;
  logic                       en, cnt_tick, rise, fall, edge_hit, ev;
  logic                       tof_set, ovr_set, capst_wr, rd_hit;
  logic [PRESCALE_BITLEN-1:0] ps_mask;

  assign ps  = capctr_q[7:5];
  assign en  = capctr_q[4];

  // Low PS bits of the prescaler must all be ones for a count tick.
  for (genvar gi = 0; gi < PRESCALE_BITLEN; gi++) begin : g_ps_mask
    assign ps_mask[gi] = (ps > 3'(gi));
  end
  assign cnt_tick = ((presc_q & ps_mask) == ps_mask);

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    case (capctr_q[3:2])
      2'b01:   edge_hit = fall;
      2'b10:   edge_hit = rise | fall;
      default: edge_hit = rise;
    endcase
  end

  assign ev       = en & edge_hit;
  assign tof_set  = en & cnt_tick & (&cnt_q);
  assign ovr_set  = ev & capctr_q[0];
  assign capst_wr = wr & ~wr_bit & (wr_addr == ADDR_CAPST);
  assign capf     = capctr_q[0] & capctr_q[1];

  always_comb begin
    capctr_d = capctr_q;
    if (wr & ~wr_bit & (wr_addr == ADDR_CAPCTR))
      capctr_d = data_in;
    else if (wr & wr_bit & (wr_addr[7:3] == BLK_CAPCTR))
      capctr_d[wr_addr[2:0]] = bit_in;
    // A capture in the same cycle as a software clear still leaves CF set.
    if (ev)
      capctr_d[0] = 1'b1;
  end

  always_comb begin
    cnt_d   = cnt_q;
    presc_d = presc_q;
    if (en) begin
      presc_d = presc_q + 1'b1;
      if (cnt_tick)
        cnt_d = cnt_q + 1'b1;
    end
  end

  assign cap_d    = ev ? cnt_q : cap_q;
  assign ovr_d    = (capst_wr ? data_in[0] : ovr_q) | ovr_set;
  assign tof_d    = (capst_wr ? data_in[1] : tof_q) | tof_set;
  assign shadow_d = (rd & ~rd_bit & (rd_addr == ADDR_CAPL)) ? cap_q[15:8] : shadow_q;

  always_comb begin
    rdata_d = 8'h00;
    rd_hit  = 1'b1;
    case (rd_addr)
      ADDR_CAPCTR: rdata_d = capctr_q;
      ADDR_CAPH:   rdata_d = shadow_q;
      ADDR_CAPL:   rdata_d = cap_q[7:0];
      ADDR_CAPST:  rdata_d = {6'b000000, tof_q, ovr_q};
      default:     rd_hit  = 1'b0;
    endcase
  end

  assign rdata_en_d = rd & ~rd_bit & rd_hit;
  assign rbit_en_d  = rd & rd_bit & (rd_addr[7:3] == BLK_CAPCTR);
  assign rbit_d     = capctr_q[rd_addr[2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capctr_q   <= CAPCTR_RSTVAL;
      cnt_q      <= '0;
      presc_q    <= '0;
      cap_q      <= '0;
      shadow_q   <= '0;
      ovr_q      <= 1'b0;
      tof_q      <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      rdata_q    <= '0;
      rdata_en_q <= 1'b0;
      rbit_q     <= 1'b0;
      rbit_en_q  <= 1'b0;
    end else begin
      capctr_q   <= capctr_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      cap_q      <= cap_d;
      shadow_q   <= shadow_d;
      ovr_q      <= ovr_d;
      tof_q      <= tof_d;
      s1_q       <= pin_cap;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      rdata_q    <= rdata_d;
      rdata_en_q <= rdata_en_d;
      rbit_q     <= rbit_d;
      rbit_en_q  <= rbit_en_d;
    end
  end

  assign data_out = rdata_en_q ? rdata_q : 8'hzz;
  assign bit_out  = rbit_en_q ? rbit_q : 1'bz;

endmodule
